// File: rtl/prg_injector_pkg.sv
// prg_injector_pkg: shared states and memory map for the program injector.
// The KBUF state exists only when PRG_INJECTOR_AUTORUN_EN is defined.
package prg_injector_pkg;
`ifdef PRG_INJECTOR_AUTORUN_EN
  typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, PATCH, KBUF, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, PATCH, DONE} state_t;
`endif
  localparam int MAX_PTR = 8;
  // Entries past the fourth are only reached when NPTR is raised above 4
  localparam logic [0:MAX_PTR-1][15:0] PTR_ADDR = {16'h002D, 16'h002F, 16'h0031, 16'h00AE,
                                                   16'h00B0, 16'h00B2, 16'h00B4, 16'h00B6};
  localparam logic [15:0] KBUF_ADDR = 16'h0527;
  localparam logic [15:0] KBUF_CNT_ADDR = 16'h00EF;
  localparam logic [0:3][7:0] AUTORUN_STR = {8'h52, 8'h55, 8'h4E, 8'h0D};
  localparam logic [7:0] AUTORUN_LEN = 8'd4;
endpackage

// File: rtl/prg_mem_writer.sv
// prg_mem_writer: issues one memory write and holds mem_wr until mem_ack.
module prg_mem_writer #(
  parameter int AW = 16
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    data,
  input  logic          mem_ack,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_data,
  output logic          done
);
  assign done = mem_wr & mem_ack;
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      mem_wr <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else if (abort) begin
      mem_wr <= 1'b0;
    end else if (start) begin
      mem_wr <= 1'b1;
      mem_addr <= addr;
      mem_data <= data;
    end else if (done) begin
      mem_wr <= 1'b0;
    end
endmodule

// File: rtl/prg_injector.sv
// prg_injector: loads a headered program into memory, patches end pointers;
// PRG_INJECTOR_AUTORUN_EN adds a keyboard-buffer autorun stage after patching.
module prg_injector
  import prg_injector_pkg::*;
#(
  parameter int          AW    = 16,
  parameter int          NPTR  = 4,
  parameter logic [7:0]  INDEX = 8'd1
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic          ioctl_wait,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_data,
  output logic          mem_wr,
  input  logic          mem_ack,
  output logic          busy,
  output logic [AW-1:0] load_end,
  output logic          err_overflow
);
  state_t state, state_n;
  logic [AW-1:0] cur_addr, addr_inc, waddr;
  logic [23:0] le_ext;
  logic [7:0] wdata;
  logic [3:0] idx;
  logic has_data, drop, sel, loading, post, abort, start, wr_done;
`ifdef PRG_INJECTOR_AUTORUN_EN
  localparam state_t AFTER_PATCH = KBUF;
  assign post = state == PATCH || state == KBUF;
`else
  localparam state_t AFTER_PATCH = DONE;
  assign post = state == PATCH;
`endif
  assign sel = ioctl_download && ioctl_index == INDEX;
  assign loading = state == HDR || state == DATA;
  assign abort = post && sel;
  assign addr_inc = cur_addr + 1'b1;
  assign le_ext = 24'(load_end);
  assign ioctl_wait = state == WRITE;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    start = 1'b0;
    waddr = cur_addr;
    wdata = ioctl_dout;
    case (state)
      IDLE: state_n = sel ? HDR : IDLE;
      HDR, DATA:
        if (!ioctl_download) state_n = has_data ? PATCH : DONE;
        else if (ioctl_wr && ioctl_addr > 25'd1 && !drop) begin
          state_n = WRITE;
          start = 1'b1;
        end else if (ioctl_wr && ioctl_addr == 25'd1) state_n = DATA;
      WRITE: state_n = wr_done ? DATA : WRITE;
      PATCH: begin
        waddr = AW'(PTR_ADDR[idx[3:1]]) + AW'(idx[0]);
        wdata = idx[0] ? le_ext[15:8] : le_ext[7:0];
        start = !mem_wr;
        state_n = (wr_done && idx == 4'(2*NPTR-1)) ? AFTER_PATCH : PATCH;
      end
`ifdef PRG_INJECTOR_AUTORUN_EN
      KBUF: begin
        waddr = (idx == 4'd4) ? AW'(KBUF_CNT_ADDR) : AW'(KBUF_ADDR) + AW'(idx);
        wdata = (idx == 4'd4) ? AUTORUN_LEN : AUTORUN_STR[idx[1:0]];
        start = !mem_wr;
        state_n = (wr_done && idx == 4'd4) ? DONE : KBUF;
      end
`endif
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) begin
      state_n = HDR;
      start = 1'b0;
    end
  end
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      state <= IDLE;
      cur_addr <= '0;
      load_end <= '0;
      err_overflow <= 1'b0;
      drop <= 1'b0;
      has_data <= 1'b0;
      idx <= '0;
    end else begin
      state <= state_n;
      idx <= (state_n != state) ? 4'd0 : idx + 4'(wr_done);
      if (state_n == HDR && state != HDR) begin
        has_data <= 1'b0;
        drop <= 1'b0;
      end
      if (abort) err_overflow <= 1'b0;
      if (loading && ioctl_download && ioctl_wr) begin
        if (ioctl_addr == 25'd0) cur_addr <= AW'(ioctl_dout);
        if (ioctl_addr == 25'd1) cur_addr <= AW'({ioctl_dout, cur_addr[7:0]});
        if (ioctl_addr > 25'd1) has_data <= 1'b1;
      end
      // Wrapping to zero poisons the rest of this download
      if (state == WRITE && wr_done) begin
        cur_addr <= addr_inc;
        if (addr_inc == '0) begin
          err_overflow <= 1'b1;
          drop <= 1'b1;
        end
      end
      if (loading && !ioctl_download && has_data) load_end <= cur_addr;
    end
  prg_mem_writer #(.AW(AW)) u_writer (
    .clk_sys(clk_sys),
    .reset(reset),
    .start(start),
    .abort(abort),
    .addr(waddr),
    .data(wdata),
    .mem_ack(mem_ack),
    .mem_wr(mem_wr),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .done(wr_done)
  );
endmodule
